telemetry_frame_sequencer: RTL and testbench

Snapshot-and-stream sequencer between the measurement datapath (ADC channels, shear/point/OPD results, counter) and the host readout path. On a datapath sample strobe it atomically captures all N_CH 32-bit channel values and then streams them as one framed packet (header, channel words, optional checksum) over a valid/ready stream interface. It gives the readout path one coherent sample set per frame, with programmable decimation and counting of dropped samples.

---
 rtl/telemetry_frame_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_telemetry_frame_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_frame_sequencer.sv
// telemetry_frame_sequencer
//
// Captures a coherent snapshot of N_CH 32-bit channel values on a datapath
// sample strobe and streams it to the host as one framed packet:
//   header {SYNC_WORD, N_CH[7:0], seq}, channel 0 .. N_CH-1, optional checksum.
// Decimation selects every decim_i-th strobe. Eligible strobes that arrive
// while a frame is still streaming are counted as drops (saturating).
//
// Optional feature macro: TELEMETRY_FRAME_CSUM_EN
//   defined   -> a checksum word (32-bit sum of header and all channel words)
//                follows the last channel word and carries m_last_o
//   undefined -> the frame ends on channel N_CH-1
//
// Ports
//   clk            system clock
//   rst            synchronous active-high reset
//   enable_i       capture enable, sampled with each strobe
//   decim_i        capture every decim_i-th strobe (0 behaves as 1)
//   sample_valid_i one-cycle strobe: ch_data_i holds a new sample set
//   ch_data_i      channel k in bits [32k+31:32k]
//   m_data_o       stream word
//   m_valid_o      stream word valid
//   m_ready_i      downstream ready
//   m_last_o       final word of frame
//   busy_o         frame in progress
//   seq_o          sequence number of the next frame to be emitted
//   drop_cnt_o     eligible captures lost while busy, saturating at 16'hFFFF

module telemetry_frame_sequencer #(
  parameter int          N_CH      = 22,
  parameter logic [15:0] SYNC_WORD = 16'hA5C3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic [15:0]          decim_i,
  input  logic                 sample_valid_i,
  input  logic [N_CH*32-1:0]   ch_data_i,
  output logic [31:0]          m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 m_last_o,
  output logic                 busy_o,
  output logic [7:0]           seq_o,
  output logic [15:0]          drop_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HEADER,
`ifdef TELEMETRY_FRAME_CSUM_EN
    ST_DATA,
    ST_CSUM
`else
    ST_DATA
`endif
  } state_t;

  localparam logic [7:0] NCH8     = 8'(N_CH);
  localparam logic [7:0] LAST_IDX = 8'(N_CH - 1);

  state_t              r_state;
  logic [N_CH*32-1:0]  r_snap;
  logic [31:0]         r_data;
  logic                r_valid;
  logic                r_last;
  logic [7:0]          r_seq;
  logic [15:0]         r_drop;
  logic [15:0]         r_dcnt;
  logic [7:0]          r_idx;
`ifdef TELEMETRY_FRAME_CSUM_EN
  logic [31:0]         r_sum;
`endif

  logic        w_fire;
  logic        w_lastBeat;
  logic [15:0] w_decimM1;
  logic        w_strobeEn;
  logic        w_eligible;
  logic        w_capReady;
  logic        w_capture;
  logic [7:0]  w_seqNext;
  logic [31:0] w_header;

  // Handshake and capture qualification. A capture is allowed while idle and
  // also in the very cycle the final beat leaves, which is what lets frames
  // run back to back without a bubble. The header of such a frame must
  // already carry the incremented sequence number.
  assign w_fire     = r_valid & m_ready_i;
  assign w_lastBeat = w_fire & r_last;
  assign w_decimM1  = (decim_i == 16'd0) ? 16'd0 : decim_i - 16'd1;
  assign w_strobeEn = sample_valid_i & enable_i;
  assign w_eligible = w_strobeEn & (r_dcnt == w_decimM1);
  assign w_capReady = (r_state == ST_IDLE) | w_lastBeat;
  assign w_capture  = w_eligible & w_capReady;
  assign w_seqNext  = w_lastBeat ? r_seq + 8'd1 : r_seq;
  assign w_header   = {SYNC_WORD, NCH8, w_seqNext};

  // Frame sequencer. All stream outputs are registered; the next word is
  // loaded whenever the current one is accepted. The snapshot is consumed by
  // shifting it down one channel per data beat, so the low word is always
  // the next channel to send and ch_data_i is only looked at on capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_data  <= 32'd0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_seq   <= 8'd0;
      r_drop  <= 16'd0;
      r_dcnt  <= 16'd0;
      r_idx   <= 8'd0;
`ifdef TELEMETRY_FRAME_CSUM_EN
      r_sum   <= 32'd0;
`endif
    end else begin
      if (w_strobeEn) begin
        r_dcnt <= w_eligible ? 16'd0 : r_dcnt + 16'd1;
      end

      if (w_eligible && !w_capReady && (r_drop != 16'hFFFF)) begin
        r_drop <= r_drop + 16'd1;
      end

      if (w_lastBeat) begin
        r_seq <= r_seq + 8'd1;
      end

      if (w_capture) begin
        r_snap  <= ch_data_i;
        r_state <= ST_HEADER;
        r_valid <= 1'b1;
        r_last  <= 1'b0;
        r_data  <= w_header;
`ifdef TELEMETRY_FRAME_CSUM_EN
        r_sum   <= w_header;
`endif
      end else if (w_lastBeat) begin
        r_state <= ST_IDLE;
        r_valid <= 1'b0;
        r_last  <= 1'b0;
      end else if (w_fire) begin
        case (r_state)
          ST_HEADER: begin
            r_state <= ST_DATA;
            r_idx   <= 8'd0;
            r_data  <= r_snap[31:0];
            r_snap  <= r_snap >> 32;
`ifdef TELEMETRY_FRAME_CSUM_EN
            r_last  <= 1'b0;
`else
            r_last  <= (LAST_IDX == 8'd0);
`endif
          end
          ST_DATA: begin
`ifdef TELEMETRY_FRAME_CSUM_EN
            r_sum <= r_sum + r_data;
            if (r_idx == LAST_IDX) begin
              r_state <= ST_CSUM;
              r_data  <= r_sum + r_data;
              r_last  <= 1'b1;
            end else begin
              r_idx  <= r_idx + 8'd1;
              r_data <= r_snap[31:0];
              r_snap <= r_snap >> 32;
              r_last <= 1'b0;
            end
`else
            r_idx  <= r_idx + 8'd1;
            r_data <= r_snap[31:0];
            r_snap <= r_snap >> 32;
            r_last <= ((r_idx + 8'd1) == LAST_IDX);
`endif
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign m_data_o   = r_data;
  assign m_valid_o  = r_valid;
  assign m_last_o   = r_last;
  assign busy_o     = (r_state != ST_IDLE);
  assign seq_o      = r_seq;
  assign drop_cnt_o = r_drop;

endmodule

// File: tb/tb_telemetry_frame_sequencer.sv
// tb_telemetry_frame_sequencer
//
// Self-checking bench for telemetry_frame_sequencer (N_CH = 22).
// A frame-level reference model predicts captures, drops and the full beat
// stream; a monitor records every accepted beat and checks that stalled
// words stay stable. Honours TELEMETRY_FRAME_CSUM_EN when defined.

module tb_telemetry_frame_sequencer;

  localparam int N_CH = 22;
`ifdef TELEMETRY_FRAME_CSUM_EN
  localparam int FLEN = N_CH + 2;
`else
  localparam int FLEN = N_CH + 1;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                enable_i = 1'b0;
  logic [15:0]         decim_i = 16'd1;
  logic                sample_valid_i = 1'b0;
  logic [N_CH*32-1:0]  ch_data_i;
  logic [31:0]         m_data_o;
  logic                m_valid_o;
  logic                m_ready_i = 1'b1;
  logic                m_last_o;
  logic                busy_o;
  logic [7:0]          seq_o;
  logic [15:0]         drop_cnt_o;

  telemetry_frame_sequencer #(.N_CH(N_CH), .SYNC_WORD(16'hA5C3)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable_i),
    .decim_i        (decim_i),
    .sample_valid_i (sample_valid_i),
    .ch_data_i      (ch_data_i),
    .m_data_o       (m_data_o),
    .m_valid_o      (m_valid_o),
    .m_ready_i      (m_ready_i),
    .m_last_o       (m_last_o),
    .busy_o         (busy_o),
    .seq_o          (seq_o),
    .drop_cnt_o     (drop_cnt_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t expQ[$];
  beat_t gotQ[$];

  int checks = 0;
  int errors = 0;

  // Reference model state: frame-level view of the sequencer
  logic [15:0] mDcnt = 16'd0;
  logic [7:0]  mSeq = 8'd0;
  int          mDrop = 0;
  int          mNextFree = 0;
  bit          useModel = 1'b1;
  bit          randData = 1'b0;

  // Records every accepted beat and checks that a stalled word is held
  logic        pValid, pReady, pRst, pLast;
  logic [31:0] pData;
  bit          pInit = 1'b0;

  always @(negedge clk) begin
    if (pInit && !pRst && pValid && !pReady) begin
      checks++;
      if (!(m_valid_o === 1'b1 && m_data_o === pData && m_last_o === pLast)) begin
        errors++;
        $display("[TB] FAIL stall hold: got v=%0b d=%08h l=%0b expected v=1 d=%08h l=%0b",
                 m_valid_o, m_data_o, m_last_o, pData, pLast);
      end
    end
    if (!rst && m_valid_o && m_ready_i) begin
      gotQ.push_back('{data: m_data_o, last: m_last_o});
    end
    pValid = m_valid_o;
    pReady = m_ready_i;
    pRst   = rst;
    pLast  = m_last_o;
    pData  = m_data_o;
    pInit  = 1'b1;
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Expected beat sequence of one frame built straight from the frame format
  task automatic buildFrame(input logic [N_CH*32-1:0] d, input logic [7:0] s);
    logic [31:0] hdr;
    logic [31:0] sum;
    logic [31:0] w;
    hdr = {16'hA5C3, 8'(N_CH), s};
    sum = hdr;
    expQ.push_back('{data: hdr, last: 1'b0});
    for (int k = 0; k < N_CH; k++) begin
      w = d[32*k +: 32];
      sum = sum + w;
`ifdef TELEMETRY_FRAME_CSUM_EN
      expQ.push_back('{data: w, last: 1'b0});
`else
      expQ.push_back('{data: w, last: (k == N_CH - 1)});
`endif
    end
`ifdef TELEMETRY_FRAME_CSUM_EN
    expQ.push_back('{data: sum, last: 1'b1});
`endif
  endtask

  // Drives one cycle of inputs, updates the model for the edge that will
  // sample them, and returns 1 time unit after that edge. With ready held
  // high a frame captured at edge e occupies the stream until edge e+FLEN,
  // where the next capture is already allowed.
  task automatic applyStimulus(input bit r, input bit sv, input bit en,
                               input logic [15:0] dec, input bit rdy);
    int e;
    logic [15:0] decM1;
    rst = r;
    sample_valid_i = sv;
    enable_i = en;
    decim_i = dec;
    m_ready_i = rdy;
    if (randData) begin
      for (int k = 0; k < N_CH; k++) ch_data_i[32*k +: 32] = $urandom;
    end
    e = cyc + 1;
    if (r) begin
      mDcnt = 16'd0;
      mSeq = 8'd0;
      mDrop = 0;
      mNextFree = e + 1;
      expQ.delete();
      gotQ.delete();
    end else if (useModel && sv && en) begin
      decM1 = (dec == 16'd0) ? 16'd0 : dec - 16'd1;
      if (mDcnt == decM1) begin
        mDcnt = 16'd0;
        if (e >= mNextFree) begin
          buildFrame(ch_data_i, mSeq);
          mSeq = mSeq + 8'd1;
          mNextFree = e + FLEN;
        end else if (mDrop < 65535) begin
          mDrop++;
        end
      end else begin
        mDcnt = mDcnt + 16'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b1, 16'd1, 1'b1);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'd1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'd1, 1'b1);
  endtask

  task automatic setPattern();
    for (int k = 0; k < N_CH; k++) ch_data_i[32*k +: 32] = 32'h1000_0000 + k;
  endtask

  function automatic int countFrames();
    int n = 0;
    foreach (gotQ[i]) if (gotQ[i].last) n++;
    return n;
  endfunction

  task automatic compareQueues(input string name);
    checkOutput({name, " beat count"}, 32'(gotQ.size()), 32'(expQ.size()));
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++) begin
      checks++;
      if (gotQ[i].data !== expQ[i].data || gotQ[i].last !== expQ[i].last) begin
        errors++;
        $display("[TB] FAIL %s beat %0d: got %08h/%0b expected %08h/%0b",
                 name, i, gotQ[i].data, gotQ[i].last, expQ[i].data, expQ[i].last);
      end
    end
    gotQ.delete();
    expQ.delete();
  endtask

  typedef struct {
    bit          r;
    bit          sv;
    bit          en;
    logic [15:0] dec;
    bit          rdy;
    bit          eV;
    bit          eL;
    bit          eB;
    logic [31:0] eD;
    logic [7:0]  eS;
    logic [15:0] eDr;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [31:0] lastWord;
    bit seen;
    int bubbles;
    int nf;

    setPattern();

    // Reset state, header latency, stall hold and drops while busy
    tbl[0] = '{1'b1, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 8'd0, 16'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 8'd0, 16'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 16'd1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA5C3_1600, 8'd0, 16'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 16'd1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA5C3_1600, 8'd0, 16'd0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 16'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0000, 8'd0, 16'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 16'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0001, 8'd0, 16'd0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 16'd1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h1000_0001, 8'd0, 16'd0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0002, 8'd0, 16'd1};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 16'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0003, 8'd0, 16'd1};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h1000_0004, 8'd0, 16'd2};

    for (int i = 0; i < 10; i++) begin
      applyStimulus(tbl[i].r, tbl[i].sv, tbl[i].en, tbl[i].dec, tbl[i].rdy);
      checkOutput($sformatf("vec%0d valid", i), 32'(m_valid_o), 32'(tbl[i].eV));
      checkOutput($sformatf("vec%0d last", i), 32'(m_last_o), 32'(tbl[i].eL));
      checkOutput($sformatf("vec%0d busy", i), 32'(busy_o), 32'(tbl[i].eB));
      checkOutput($sformatf("vec%0d data", i), m_data_o, tbl[i].eD);
      checkOutput($sformatf("vec%0d seq", i), 32'(seq_o), 32'(tbl[i].eS));
      checkOutput($sformatf("vec%0d drop", i), 32'(drop_cnt_o), 32'(tbl[i].eDr));
    end

    // Run the first frame out and check its closing word and sequence step
`ifdef TELEMETRY_FRAME_CSUM_EN
    lastWord = 32'hA5C3_1600;
    for (int k = 0; k < N_CH; k++) lastWord = lastWord + 32'h1000_0000 + k;
`else
    lastWord = 32'h1000_0000 + N_CH - 1;
`endif
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 16'd1, 1'b1);
      if (m_valid_o && m_last_o) begin
        seen = 1'b1;
        checkOutput("frame1 last word", m_data_o, lastWord);
      end
    end
    checkOutput("frame1 last seen", 32'(seen), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'd1, 1'b1);
    checkOutput("frame1 valid after", 32'(m_valid_o), 32'd0);
    checkOutput("frame1 busy after", 32'(busy_o), 32'd0);
    checkOutput("frame1 seq after", 32'(seq_o), 32'd1);
    compareQueues("frame1");

    // Random backpressure during a frame while ch_data_i keeps changing
    doReset();
    randData = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd1, 1'b0);
    for (int i = 0; i < 200; i++) applyStimulus(1'b0, 1'b0, 1'b1, 16'd1, 1'($urandom % 2));
    idle(30);
    checkOutput("stall seq", 32'(seq_o), 32'd1);
    compareQueues("stall");

    // Decimation by 4 with widely spaced strobes
    doReset();
    for (int s = 0; s < 12; s++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 16'd4, 1'b1);
      repeat (39) applyStimulus(1'b0, 1'b0, 1'b1, 16'd4, 1'b1);
    end
    nf = countFrames();
    checkOutput("decim4 frames", 32'(nf), 32'd3);
    checkOutput("decim4 drop", 32'(drop_cnt_o), 32'd0);
    checkOutput("decim4 seq", 32'(seq_o), 32'd3);
    compareQueues("decim4");

    // Strobes every 5 cycles: one capture then four drops per 25 cycles
    doReset();
    for (int s = 0; s < 100; s++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 16'd1, 1'b1);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, 16'd1, 1'b1);
    end
    idle(30);
    checkOutput("period5 drop", 32'(drop_cnt_o), 32'd80);
    checkOutput("period5 drop model", 32'(drop_cnt_o), 32'(mDrop));
    nf = countFrames();
    checkOutput("period5 frames", 32'(nf), 32'd20);
    compareQueues("period5");

    // Back-to-back frames, 257 of them, sequence wrap 255 -> 0
    doReset();
    bubbles = 0;
    for (int f = 0; f < 257; f++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 16'd1, 1'b1);
      if (!m_valid_o) bubbles++;
      if (f == 255) checkOutput("seq before wrap", 32'(seq_o), 32'd255);
      if (f == 256) checkOutput("seq wrap", 32'(seq_o), 32'd0);
      repeat (FLEN - 1) begin
        applyStimulus(1'b0, 1'b0, 1'b1, 16'd1, 1'b1);
        if (!m_valid_o) bubbles++;
      end
    end
    idle(5);
    checkOutput("b2b bubbles", 32'(bubbles), 32'd0);
    checkOutput("b2b seq", 32'(seq_o), 32'd1);
    checkOutput("b2b drop", 32'(drop_cnt_o), 32'd0);
    compareQueues("b2b");

    // Reset while data word 10 is on the bus
    randData = 1'b0;
    doReset();
    setPattern();
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd1, 1'b1);
    idle(FLEN + 2);
    checkOutput("pre-abort seq", 32'(seq_o), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd1, 1'b1);
    idle(11);
    checkOutput("abort word10", m_data_o, 32'h1000_000A);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'd1, 1'b1);
    checkOutput("abort valid", 32'(m_valid_o), 32'd0);
    checkOutput("abort seq", 32'(seq_o), 32'd0);
    checkOutput("abort busy", 32'(busy_o), 32'd0);
    checkOutput("abort last", 32'(m_last_o), 32'd0);
    idle(3);
    checkOutput("abort stays idle", 32'(m_valid_o), 32'd0);

    // Randomised traffic against the model, one decimation setting per block
    randData = 1'b1;
    for (int b = 0; b < 6; b++) begin
      doReset();
      for (int i = 0; i < 500; i++) begin
        applyStimulus(1'b0, ($urandom % 4) == 0, ($urandom % 8) != 0, 16'(b % 4), 1'b1);
      end
      idle(FLEN + 2);
      checkOutput($sformatf("rand%0d drop", b), 32'(drop_cnt_o), 32'(mDrop));
      checkOutput($sformatf("rand%0d seq", b), 32'(seq_o), 32'(mSeq));
      compareQueues($sformatf("rand%0d", b));
    end

    // Drop counter saturation: stream stalled so every strobe is dropped
    randData = 1'b0;
    doReset();
    useModel = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd1, 1'b0);
    repeat (65534) applyStimulus(1'b0, 1'b1, 1'b1, 16'd1, 1'b0);
    checkOutput("drop FFFE", 32'(drop_cnt_o), 32'h0000_FFFE);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'd1, 1'b0);
    checkOutput("drop FFFF", 32'(drop_cnt_o), 32'h0000_FFFF);
    repeat (5) applyStimulus(1'b0, 1'b1, 1'b1, 16'd1, 1'b0);
    checkOutput("drop saturated", 32'(drop_cnt_o), 32'h0000_FFFF);
    checkOutput("sat header held", m_data_o, 32'hA5C3_1600);
    useModel = 1'b1;
    doReset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
